// File: rtl/approx_error_monitor.sv
// Windowed error-distance monitor for an approximate adder: measures |A+B - SUM|
// over WIN accepted samples and reports error count, maximum and saturating sum.
module approx_error_monitor #(
  parameter int N     = 8,
  parameter int WIN   = 256,
  parameter int SUM_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [N:0]       SUM,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      err_cnt,
  output logic [N:0]       max_ed,
  output logic [SUM_W-1:0] sum_ed,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  // Accumulator add width: wide enough that sum_ed + ED cannot wrap before the clamp.
  localparam int              AW      = ((SUM_W > N + 1) ? SUM_W : N + 1) + 1;
  localparam logic [15:0]     LAST    = 16'(WIN - 1);
  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  state_t         state;
  logic [15:0]    sample_cnt;
  logic           drain_cnt;
  logic           s1_valid;
  logic           s1_nz;
  logic [N:0]     s1_ed;

  logic           accept;
  logic [N:0]     exact;
  logic [N:0]     ed;
  logic [AW-1:0]  sum_ext;
  logic [SUM_W-1:0] sum_next;

  assign in_ready  = (state == RUN);
  assign res_valid = (state == REPORT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    exact   = {1'b0, A} + {1'b0, B};
    ed      = (exact >= SUM) ? (exact - SUM) : (SUM - exact);
    sum_ext = AW'(sum_ed) + AW'(s1_ed);
    if (sum_ext > AW'(SUM_MAX)) sum_next = SUM_MAX;
    else                        sum_next = sum_ext[SUM_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      drain_cnt  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_nz      <= 1'b0;
      s1_ed      <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else begin
      // Stage 1: register ED of the accepted sample.
      s1_valid <= accept;
      s1_ed    <= ed;
      s1_nz    <= |ed;

      // Stage 2: fold the stage-1 result into the window statistics.
      if (s1_valid) begin
        if (s1_nz)          err_cnt <= err_cnt + 16'd1;
        if (s1_ed > max_ed) max_ed  <= s1_ed;
        sum_ed <= sum_next;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            sample_cnt <= '0;
            err_cnt    <= '0;
            max_ed     <= '0;
            sum_ed     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            sample_cnt <= sample_cnt + 16'd1;
            if (sample_cnt == LAST) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the last sample pass both pipeline stages.
          if (drain_cnt) state <= REPORT;
          drain_cnt <= 1'b1;
        end
        REPORT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor: a WIN=4 instance for the main
// scenarios and a WIN=8, SUM_W=10 instance for accumulator saturation.
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, res_ready;
  logic [7:0]  a, b;
  logic [8:0]  sum;
  logic        in_ready, res_valid, busy;
  logic [15:0] err_cnt;
  logic [8:0]  max_ed;
  logic [23:0] sum_ed;

  logic        s_start, s_in_valid, s_res_ready;
  logic [7:0]  s_a, s_b;
  logic [8:0]  s_sum;
  logic        s_in_ready, s_res_valid, s_busy;
  logic [15:0] s_err_cnt;
  logic [8:0]  s_max_ed;
  logic [9:0]  s_sum_ed;

  int checks = 0;
  int errors = 0;

  logic [7:0] va [4];
  logic [7:0] vb [4];
  logic [8:0] vs [4];

  always #5 clk = ~clk;

  approx_error_monitor #(.N(8), .WIN(4), .SUM_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .A(a), .B(b), .SUM(sum), .res_valid(res_valid),
    .res_ready(res_ready), .err_cnt(err_cnt), .max_ed(max_ed),
    .sum_ed(sum_ed), .busy(busy)
  );

  approx_error_monitor #(.N(8), .WIN(8), .SUM_W(10)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .A(s_a), .B(s_b), .SUM(s_sum), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .err_cnt(s_err_cnt), .max_ed(s_max_ed),
    .sum_ed(s_sum_ed), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, res_valid, busy, s_in_ready, s_res_valid, s_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {in_ready, res_valid, busy, s_in_ready, s_res_valid, s_busy});
    end
    checks++;
    if ({err_cnt, max_ed, sum_ed} !== '0) begin
      errors++;
      $display("FAIL reset_results: got cnt=%0d max=%0d sum=%0d, expected 0/0/0",
               err_cnt, max_ed, sum_ed);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Runs one WIN=4 window from the va/vb/vs table, checks DRAIN timing and
  // leaves the DUT in REPORT. A fifth sample is offered during DRAIN.
  task automatic run_window(input bit gaps, input logic [15:0] e_cnt,
                            input logic [8:0] e_max, input logic [23:0] e_sum,
                            input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({in_ready, busy, res_valid} !== 3'b110) begin
      errors++;
      $display("FAIL %s_run_entry: got ready/busy/valid=%b, expected 110", name,
               {in_ready, busy, res_valid});
    end
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
      end
      a = va[i]; b = vb[i]; sum = vs[i]; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_ready_%0d: got %b, expected 1", name, i, in_ready);
      end
      tick();
    end
    a = 8'hFF; b = 8'h00; sum = 9'h000;
    checks++;
    if ({in_ready, busy, res_valid} !== 3'b010) begin
      errors++;
      $display("FAIL %s_drain1: got ready/busy/valid=%b, expected 010", name,
               {in_ready, busy, res_valid});
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({in_ready, busy, res_valid} !== 3'b010) begin
      errors++;
      $display("FAIL %s_drain2: got ready/busy/valid=%b, expected 010", name,
               {in_ready, busy, res_valid});
    end
    tick();
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_report_latency: res_valid=%b, expected 1", name, res_valid);
    end
    checks++;
    if ({err_cnt, max_ed, sum_ed} !== {e_cnt, e_max, e_sum}) begin
      errors++;
      $display("FAIL %s_results: got cnt=%0d max=%0d sum=%0d, expected %0d/%0d/%0d",
               name, err_cnt, max_ed, sum_ed, e_cnt, e_max, e_sum);
    end
  endtask

  task automatic finish_report(input string name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if ({busy, res_valid, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL %s_to_idle: got busy/valid/ready=%b, expected 000", name,
               {busy, res_valid, in_ready});
    end
  endtask

  task automatic load_error_vectors();
    va[0] = 8'h0F; vb[0] = 8'h01; vs[0] = 9'h00F;
    va[1] = 8'hFF; vb[1] = 8'hFF; vs[1] = 9'h1FE;
    va[2] = 8'h80; vb[2] = 8'h80; vs[2] = 9'h080;
    va[3] = 8'h10; vb[3] = 8'h10; vs[3] = 9'h030;
  endtask

  task automatic test_exact();
    va[0] = 8'h12; vb[0] = 8'h34; vs[0] = 9'h046;
    va[1] = 8'hFF; vb[1] = 8'h01; vs[1] = 9'h100;
    va[2] = 8'h00; vb[2] = 8'h00; vs[2] = 9'h000;
    va[3] = 8'h80; vb[3] = 8'h7F; vs[3] = 9'h0FF;
    run_window(1'b0, 16'd0, 9'd0, 24'd0, "exact");
    finish_report("exact");
  endtask

  task automatic test_errors();
    load_error_vectors();
    run_window(1'b0, 16'd3, 9'd128, 24'd145, "errors");
    finish_report("errors");
  endtask

  task automatic test_gaps();
    load_error_vectors();
    run_window(1'b1, 16'd3, 9'd128, 24'd145, "gaps");
    finish_report("gaps");
  endtask

  task automatic test_hold();
    load_error_vectors();
    run_window(1'b0, 16'd3, 9'd128, 24'd145, "hold");
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      start = 1'b0;
      checks++;
      if ({res_valid, busy, err_cnt, max_ed, sum_ed} !== {2'b11, 16'd3, 9'd128, 24'd145}) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got valid=%b busy=%b cnt=%0d max=%0d sum=%0d, expected 1/1/3/128/145",
                 i, res_valid, busy, err_cnt, max_ed, sum_ed);
      end
    end
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, res_valid, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL hold_handshake: got busy/valid/ready=%b, expected 000",
               {busy, res_valid, in_ready});
    end
    tick();
    checks++;
    if ({busy, err_cnt, max_ed, sum_ed} !== {1'b0, 16'd3, 9'd128, 24'd145}) begin
      errors++;
      $display("FAIL hold_idle_results: got busy=%b cnt=%0d max=%0d sum=%0d, expected 0/3/128/145",
               busy, err_cnt, max_ed, sum_ed);
    end
  endtask

  task automatic test_reset_mid();
    load_error_vectors();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = va[i]; b = vb[i]; sum = vs[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy, res_valid, in_ready, err_cnt, max_ed, sum_ed} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b valid=%b ready=%b cnt=%0d max=%0d sum=%0d, expected all 0",
               busy, res_valid, in_ready, err_cnt, max_ed, sum_ed);
    end
    tick();
    checks++;
    if ({busy, err_cnt, max_ed, sum_ed} !== '0) begin
      errors++;
      $display("FAIL midreset_settled: got busy=%b cnt=%0d max=%0d sum=%0d, expected all 0",
               busy, err_cnt, max_ed, sum_ed);
    end
    va[0] = 8'h01; vb[0] = 8'h01; vs[0] = 9'h000;
    va[1] = 8'h00; vb[1] = 8'h00; vs[1] = 9'h000;
    va[2] = 8'hFF; vb[2] = 8'h01; vs[2] = 9'h0F0;
    va[3] = 8'h20; vb[3] = 8'h00; vs[3] = 9'h025;
    run_window(1'b0, 16'd3, 9'd16, 24'd23, "fresh");
    finish_report("fresh");
  endtask

  task automatic test_saturate();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_a = 8'h00; s_b = 8'h00; s_sum = 9'h100; s_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (s_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL sat_ready_%0d: got %b, expected 1", i, s_in_ready);
      end
      tick();
    end
    s_in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({s_res_valid, s_err_cnt, s_max_ed, s_sum_ed} !== {1'b1, 16'd8, 9'd256, 10'd1023}) begin
      errors++;
      $display("FAIL sat_results: got valid=%b cnt=%0d max=%0d sum=%0d, expected 1/8/256/1023",
               s_res_valid, s_err_cnt, s_max_ed, s_sum_ed);
    end
    s_res_ready = 1'b1;
    tick();
    s_res_ready = 1'b0;
    checks++;
    if ({s_busy, s_res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL sat_to_idle: got busy/valid=%b, expected 00", {s_busy, s_res_valid});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; sum = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_res_ready = 1'b0;
    s_a = '0; s_b = '0; s_sum = '0;
    test_reset();
    test_exact();
    test_errors();
    test_gaps();
    test_hold();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
